// File: rtl/elevator_if.sv
// Car-controller signal bundle: calls and door handshake in, car status out.
interface elevator_if #(
    parameter int N_FLOORS = 4,
    parameter int FW       = (N_FLOORS > 1) ? $clog2(N_FLOORS) : 1
);
    logic [N_FLOORS-1:0] call_btn;
    logic                door_done;
    logic                door_open;
    logic [FW-1:0]       floor;
    logic                moving_up;
    logic                moving_down;
    logic [N_FLOORS-1:0] pending;
    logic                busy;

    modport master (
        output call_btn, door_done,
        input  door_open, floor, moving_up, moving_down, pending, busy
    );

    modport slave (
        input  call_btn, door_done,
        output door_open, floor, moving_up, moving_down, pending, busy
    );
endinterface

// File: rtl/elevator_ctrl.sv
// Elevator car-motion controller: latches floor calls, serves them in collective (SCAN) order,
// and hands each stop to the door stage with a one-cycle door_open pulse.
module elevator_ctrl #(
    parameter int N_FLOORS     = 4,
    parameter int TRAVEL_TICKS = 2000,
    parameter int DOOR_TIMEOUT = 3000
) (
    input  logic     clklento,
    input  logic     rst,
    elevator_if.slave bus
);
    localparam int FW = (N_FLOORS > 1) ? $clog2(N_FLOORS) : 1;
    localparam int TW = $clog2(TRAVEL_TICKS + 1);
    localparam int DW = $clog2(DOOR_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        MOVE_UP,
        MOVE_DOWN,
        ARRIVE,
        DOOR_WAIT
    } state_t;

    state_t              state_q, state_d;
    logic [FW-1:0]       floor_q, floor_d;
    logic [N_FLOORS-1:0] pending_q, pending_d;
    logic [TW-1:0]       travel_q, travel_d;
    logic [DW-1:0]       door_cnt_q, door_cnt_d;
    logic                has_dir_q, has_dir_d;
    logic                dir_up_q, dir_up_d;
    logic                door_done_q;
    logic                door_open_q, moving_up_q, moving_down_q, busy_q;

    logic [N_FLOORS-1:0] set_mask, clr_mask;
    logic [FW-1:0]       next_floor;
    logic                door_exit;

    function automatic logic calls_above(input logic [N_FLOORS-1:0] pend, input logic [FW-1:0] fl);
        logic any;
        any = 1'b0;
        for (int i = 0; i < N_FLOORS; i++)
            if (i > int'(fl) && pend[i]) any = 1'b1;
        return any;
    endfunction

    function automatic logic calls_below(input logic [N_FLOORS-1:0] pend, input logic [FW-1:0] fl);
        logic any;
        any = 1'b0;
        for (int i = 0; i < N_FLOORS; i++)
            if (i < int'(fl) && pend[i]) any = 1'b1;
        return any;
    endfunction

    // Stop here if called, else keep heading the same way, else reverse; up wins with no history.
    function automatic state_t decide(input logic [N_FLOORS-1:0] pend, input logic [FW-1:0] fl,
                                      input logic has_dir, input logic dir_up);
        logic above, below;
        above = calls_above(pend, fl);
        below = calls_below(pend, fl);
        if (pend[fl])
            return ARRIVE;
        else if (!has_dir || dir_up)
            return above ? MOVE_UP : (below ? MOVE_DOWN : IDLE);
        else
            return below ? MOVE_DOWN : (above ? MOVE_UP : IDLE);
    endfunction

    always_comb begin
        state_d    = state_q;
        floor_d    = floor_q;
        travel_d   = '0;
        door_cnt_d = '0;
        has_dir_d  = has_dir_q;
        dir_up_d   = dir_up_q;
        next_floor = floor_q;
        door_exit  = 1'b0;
        set_mask   = bus.call_btn;
        clr_mask   = '0;

        // The door is already serving this floor, so its button is ignored; clear beats set.
        if (state_q == ARRIVE || state_q == DOOR_WAIT)
            set_mask[floor_q] = 1'b0;
        if (state_q == ARRIVE)
            clr_mask[floor_q] = 1'b1;
        pending_d = (pending_q | set_mask) & ~clr_mask;

        case (state_q)
            IDLE: state_d = decide(pending_q, floor_q, has_dir_q, dir_up_q);
            MOVE_UP: begin
                if (travel_q == TW'(TRAVEL_TICKS - 1)) begin
                    next_floor = floor_q + 1'b1;
                    floor_d    = next_floor;
                    if (pending_q[next_floor])                state_d = ARRIVE;
                    else if (calls_above(pending_q, next_floor)) state_d = MOVE_UP;
                    else state_d = decide(pending_q, next_floor, has_dir_q, dir_up_q);
                end else begin
                    travel_d = travel_q + 1'b1;
                end
            end
            MOVE_DOWN: begin
                if (travel_q == TW'(TRAVEL_TICKS - 1)) begin
                    next_floor = floor_q - 1'b1;
                    floor_d    = next_floor;
                    if (pending_q[next_floor])                state_d = ARRIVE;
                    else if (calls_below(pending_q, next_floor)) state_d = MOVE_DOWN;
                    else state_d = decide(pending_q, next_floor, has_dir_q, dir_up_q);
                end else begin
                    travel_d = travel_q + 1'b1;
                end
            end
            ARRIVE: state_d = DOOR_WAIT;
            DOOR_WAIT: begin
                door_exit = (bus.door_done && !door_done_q) ||
                            (door_cnt_q == DW'(DOOR_TIMEOUT - 1));
                if (door_exit) state_d = decide(pending_q, floor_q, has_dir_q, dir_up_q);
                else           door_cnt_d = door_cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (state_d == MOVE_UP) begin
            has_dir_d = 1'b1;
            dir_up_d  = 1'b1;
        end else if (state_d == MOVE_DOWN) begin
            has_dir_d = 1'b1;
            dir_up_d  = 1'b0;
        end
    end

    // Outputs are decoded from the next state so they line up with the registered state.
    always_ff @(posedge clklento or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            floor_q       <= '0;
            pending_q     <= '0;
            travel_q      <= '0;
            door_cnt_q    <= '0;
            has_dir_q     <= 1'b0;
            dir_up_q      <= 1'b0;
            door_done_q   <= 1'b0;
            door_open_q   <= 1'b0;
            moving_up_q   <= 1'b0;
            moving_down_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            floor_q       <= floor_d;
            pending_q     <= pending_d;
            travel_q      <= travel_d;
            door_cnt_q    <= door_cnt_d;
            has_dir_q     <= has_dir_d;
            dir_up_q      <= dir_up_d;
            door_done_q   <= bus.door_done;
            door_open_q   <= (state_d == ARRIVE);
            moving_up_q   <= (state_d == MOVE_UP);
            moving_down_q <= (state_d == MOVE_DOWN);
            busy_q        <= (state_d != IDLE);
        end
    end

    assign bus.door_open   = door_open_q;
    assign bus.floor       = floor_q;
    assign bus.moving_up   = moving_up_q;
    assign bus.moving_down = moving_down_q;
    assign bus.pending     = pending_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_elevator_ctrl.sv
// Directed bench for elevator_ctrl: each call pushes the expected door_open (floor, cycle)
// into a scoreboard that a negedge monitor drains; status outputs are checked inline.
module tb_elevator_ctrl;
    localparam int N = 4;

    logic clk;
    logic rst;
    int   cyc;
    int   errors;
    int   checks;
    int   door_total;
    logic prev_door;

    typedef struct {
        int fl;
        int cy;
    } exp_t;
    exp_t sb[$];

    elevator_if #(.N_FLOORS(N)) bus ();

    elevator_ctrl #(
        .N_FLOORS    (N),
        .TRAVEL_TICKS(4),
        .DOOR_TIMEOUT(8)
    ) dut (
        .clklento(clk),
        .rst     (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_neg(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic expect_door(input int fl, input int cy);
        exp_t e;
        e.fl = fl;
        e.cy = cy;
        sb.push_back(e);
    endtask

    // Monitor: every door_open pulse must match the oldest expected stop.
    initial prev_door = 1'b0;
    always @(negedge clk) begin
        if (bus.door_open) begin
            exp_t e;
            door_total++;
            chk("door_back_to_back", int'(prev_door), 0);
            chk("door_moving", int'({bus.moving_up, bus.moving_down}), 0);
            if (sb.size() == 0) begin
                chk("door_unexpected", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("door_floor", int'(bus.floor), e.fl);
                chk("door_cycle", cyc, e.cy);
            end
        end
        prev_door <= bus.door_open;
    end

    initial begin
        int c;
        errors       = 0;
        checks       = 0;
        door_total   = 0;
        rst          = 1'b1;
        bus.call_btn = '0;
        bus.door_done = 1'b0;

        wait_neg(2);
        chk("rst_floor", int'(bus.floor), 0);
        chk("rst_pending", int'(bus.pending), 0);
        chk("rst_door_open", int'(bus.door_open), 0);
        chk("rst_moving", int'({bus.moving_up, bus.moving_down}), 0);
        chk("rst_busy", int'(bus.busy), 0);
        rst = 1'b0;

        // Single call to floor 2 from floor 0.
        c = 4;
        wait_neg(c);
        bus.call_btn = 4'b0100;
        expect_door(2, c + 10);
        wait_neg(c + 1);
        bus.call_btn = '0;
        chk("t2_pending_latched", int'(bus.pending), 4'b0100);
        chk("t2_still_idle", int'(bus.busy), 0);
        wait_neg(c + 2);
        chk("t2_moving_up", int'(bus.moving_up), 1);
        wait_neg(c + 6);
        chk("t2_floor1", int'(bus.floor), 1);
        wait_neg(c + 11);
        chk("t2_pending_cleared", int'(bus.pending), 0);

        // door_done rises 2 cycles after door_open: leave DOOR_WAIT on that edge.
        wait_neg(c + 12);
        chk("t3_in_door_wait", int'(bus.busy), 1);
        bus.door_done = 1'b1;
        wait_neg(c + 13);
        chk("t3_exit_on_edge", int'(bus.busy), 0);
        chk("t3_floor", int'(bus.floor), 2);

        // Same-floor call in IDLE with door_done held high: door within 2, timeout after 8.
        c = 19;
        wait_neg(c);
        bus.call_btn = 4'b0100;
        expect_door(2, c + 2);
        wait_neg(c + 1);
        bus.call_btn = '0;
        wait_neg(c + 2);
        chk("t5_floor_kept", int'(bus.floor), 2);
        wait_neg(c + 10);
        chk("t3_held_still_waiting", int'(bus.busy), 1);
        wait_neg(c + 11);
        chk("t3_held_timeout", int'(bus.busy), 0);
        bus.door_done = 1'b0;

        // Hold the current-floor button through ARRIVE and DOOR_WAIT.
        c = 32;
        wait_neg(c);
        bus.call_btn = 4'b0100;
        expect_door(2, c + 2);
        wait_neg(c + 3);
        chk("t6_pending_ignored_a", int'(bus.pending), 0);
        wait_neg(c + 7);
        chk("t6_pending_ignored_b", int'(bus.pending), 0);
        wait_neg(c + 8);
        bus.call_btn = '0;
        wait_neg(c + 12);
        chk("t6_idle", int'(bus.busy), 0);
        chk("t6_pending_end", int'(bus.pending), 0);

        // Return to ground floor.
        c = 46;
        wait_neg(c);
        bus.call_btn = 4'b0001;
        expect_door(0, c + 10);
        wait_neg(c + 1);
        bus.call_btn = '0;
        wait_neg(c + 2);
        chk("down_moving_down", int'({bus.moving_up, bus.moving_down}), 2'b01);
        wait_neg(c + 19);
        chk("down_idle_floor0", int'({bus.busy, bus.floor}), 0);

        // Collective order: call 3, then calls 0 and 2 while passing floor 1.
        c = 67;
        wait_neg(c);
        bus.call_btn = 4'b1000;
        expect_door(2, c + 10);
        expect_door(3, c + 23);
        expect_door(0, c + 44);
        wait_neg(c + 1);
        bus.call_btn = '0;
        wait_neg(c + 7);
        chk("t4_floor1", int'(bus.floor), 1);
        chk("t4_moving_up", int'(bus.moving_up), 1);
        bus.call_btn = 4'b0101;
        wait_neg(c + 8);
        bus.call_btn = '0;
        chk("t4_pending", int'(bus.pending), 4'b1101);
        wait_neg(c + 35);
        chk("t4_moving_down", int'({bus.moving_up, bus.moving_down}), 2'b01);
        chk("t4_floor3", int'(bus.floor), 3);
        wait_neg(c + 53);
        chk("t4_idle", int'(bus.busy), 0);
        chk("t4_floor0", int'(bus.floor), 0);
        chk("t4_pending_empty", int'(bus.pending), 0);

        // Asynchronous reset mid-travel at floor 2.
        c = 122;
        wait_neg(c);
        bus.call_btn = 4'b1000;
        wait_neg(c + 1);
        bus.call_btn = '0;
        wait_neg(c + 10);
        chk("t1_floor2", int'(bus.floor), 2);
        chk("t1_moving_up", int'(bus.moving_up), 1);
        wait_neg(c + 11);
        rst = 1'b1;
        #1;
        chk("t1_rst_floor", int'(bus.floor), 0);
        chk("t1_rst_pending", int'(bus.pending), 0);
        chk("t1_rst_outputs", int'({bus.moving_up, bus.moving_down, bus.busy, bus.door_open}), 0);
        wait_neg(c + 13);
        rst = 1'b0;
        wait_neg(c + 16);
        chk("t1_idle_after", int'({bus.busy, bus.floor, bus.pending}), 0);

        wait_neg(c + 17);
        chk("sb_drained", sb.size(), 0);
        chk("door_total", door_total, 7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
